// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, mstatus/mie/mip bit positions, trap cause codes, the Zicsr
// operation encoding and the read-modify-write helper used to form write data.
// -----------------------------------------------------------------------------
package csr_pkg;

   // Machine-mode CSR addresses
   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;

   // Counters (writable) and their read-only user aliases
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

   // Bit positions
   localparam int BIT_MIE  = 3;
   localparam int BIT_MPIE = 7;
   localparam int BIT_MTIE = 7;
   localparam int BIT_MTIP = 7;
   localparam int BIT_MEIE = 11;
   localparam int BIT_MEIP = 11;

   // mstatus.MPP is hardwired to machine mode
   localparam logic [31:0] MSTATUS_MPP = 32'h0000_1800;

   // Implemented bits of mcause: interrupt flag and 4-bit code
   localparam logic [31:0] MCAUSE_MASK = 32'h8000_000F;

   // Trap cause codes
   localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;
   localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;

   // Zicsr operation (csr_funct3[1:0])
   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_e;

   // New register value for a CSR instruction given the current value
   function automatic logic [31:0] csr_apply(input csr_op_e op,
                                              input logic [31:0] old,
                                              input logic [31:0] wdata);
      logic [31:0] res;
      res = old;
      case (op)
         CSR_OP_RW: res = wdata;
         CSR_OP_RS: res = old | wdata;
         CSR_OP_RC: res = old & ~wdata;
         default:   res = old;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// -----------------------------------------------------------------------------
// csr_counter64
// 64-bit wrapping performance counter with independently writable halves.
// A write to either half replaces that half and suppresses the increment in
// the same cycle.
// Ports:
//   clk, rst   core clock, synchronous active-high reset (count -> 0)
//   inc        increment request for this cycle
//   wr_lo      replace bits [31:0] with wdata
//   wr_hi      replace bits [63:32] with wdata
//   wdata      write value
//   count      current 64-bit count
// -----------------------------------------------------------------------------
module csr_counter64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   output logic [63:0] count
);

   logic [63:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 64'd0;
      end else if (wr_lo || wr_hi) begin
         if (wr_lo) cnt[31:0]  <= wdata;
         if (wr_hi) cnt[63:32] <= wdata;
      end else if (inc) begin
         cnt <= cnt + 64'd1;
      end
   end

   assign count = cnt;

endmodule

// File: rtl/csr_trap_unit.sv
// -----------------------------------------------------------------------------
// csr_trap_unit
// Machine-mode CSR file and trap sequencer for the pipelined RV32 core.
// Provides gated interrupt enables to interrupt_control, saves trap state and
// redirects fetch to mtvec on an accepted interrupt, restores state and
// redirects to mepc on mret, and serves Zicsr read/modify/write from EX.
//
// Build option: define CSR_COUNTERS_EN to implement the 64-bit mcycle and
// minstret counters. Without it the counter addresses read 0 and ignore writes.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   stall               pipeline stall (freezes CSR writes, minstret, mret)
//   csr_en              EX-stage instruction is a CSR op
//   csr_funct3          op select in bits[1:0]: 01 RW, 10 RS, 11 RC
//   csr_addr            CSR address
//   csr_wdata           rs1 value or zero-extended zimm
//   csr_rdata           combinational read of current state
//   ex_pc               PC of the EX-stage instruction
//   wfi, mret           EX-stage WFI / MRET
//   instr_retire        one instruction retires this cycle
//   sensor_irq, wdt_irq raw external / timer interrupt lines (mip)
//   interrupt_taken     trap accepted by interrupt_control
//   wfi_mode            core is sleeping in WFI
//   MEIE, MTIE          gated enables to interrupt_control
//   redirect            single-cycle combinational fetch redirect
//   redirect_pc         redirect target
// -----------------------------------------------------------------------------
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter logic [31:0] MTVEC_RST = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        csr_en,
   input  logic [2:0]  csr_funct3,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   input  logic [31:0] ex_pc,
   input  logic        wfi,
   input  logic        mret,
   input  logic        instr_retire,
   input  logic        sensor_irq,
   input  logic        wdt_irq,
   input  logic        interrupt_taken,
   input  logic        wfi_mode,
   output logic        MEIE,
   output logic        MTIE,
   output logic        redirect,
   output logic [31:0] redirect_pc
);

   // Architectural state
   logic        st_mie;
   logic        st_mpie;
   logic        en_meie;
   logic        en_mtie;
   logic [31:0] mtvec_q;
   logic [31:0] mepc_q;
   logic [31:0] mcause_q;
   logic [31:0] wfi_pc;

   csr_op_e     op;
   logic        op_writes;
   logic        csr_we;
   logic        mret_fire;
   logic [31:0] wval;
   logic [31:0] trap_epc;

   assign op = csr_op_e'(csr_funct3[1:0]);

   // RS/RC with a zero operand are pure reads and must not write
   assign op_writes = (op == CSR_OP_RW) ||
                      ((op != CSR_OP_NONE) && (csr_wdata != 32'd0));

   // interrupt_taken outranks mret, which outranks a CSR write; the loser
   // is replayed later so it must leave no trace now.
   assign mret_fire = mret && !stall && !interrupt_taken;
   assign csr_we    = csr_en && !stall && !interrupt_taken && !mret && op_writes;

   // Old value for RS/RC is the same combinational read the core sees
   assign wval     = csr_apply(op, csr_rdata, csr_wdata);
   assign trap_epc = wfi_mode ? wfi_pc : ex_pc;

`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle;
   logic [63:0] minstret;

   csr_counter64 u_mcycle (
      .clk   (clk),
      .rst   (rst),
      .inc   (1'b1),
      .wr_lo (csr_we && (csr_addr == CSR_MCYCLE)),
      .wr_hi (csr_we && (csr_addr == CSR_MCYCLEH)),
      .wdata (wval),
      .count (mcycle)
   );

   csr_counter64 u_minstret (
      .clk   (clk),
      .rst   (rst),
      .inc   (instr_retire && !stall),
      .wr_lo (csr_we && (csr_addr == CSR_MINSTRET)),
      .wr_hi (csr_we && (csr_addr == CSR_MINSTRETH)),
      .wdata (wval),
      .count (minstret)
   );

   logic unused_bits;
   assign unused_bits = csr_funct3[2];
`else
   logic unused_bits;
   assign unused_bits = csr_funct3[2] ^ instr_retire;
`endif

   // Combinational read: returns state before this cycle's write
   always_comb begin
      csr_rdata = 32'd0;
      case (csr_addr)
         CSR_MSTATUS: begin
            csr_rdata           = MSTATUS_MPP;
            csr_rdata[BIT_MIE]  = st_mie;
            csr_rdata[BIT_MPIE] = st_mpie;
         end
         CSR_MIE: begin
            csr_rdata[BIT_MEIE] = en_meie;
            csr_rdata[BIT_MTIE] = en_mtie;
         end
         CSR_MTVEC:  csr_rdata = mtvec_q;
         CSR_MEPC:   csr_rdata = mepc_q;
         CSR_MCAUSE: csr_rdata = mcause_q;
         CSR_MIP: begin
            csr_rdata[BIT_MEIP] = sensor_irq;
            csr_rdata[BIT_MTIP] = wdt_irq;
         end
`ifdef CSR_COUNTERS_EN
         CSR_MCYCLE,    CSR_CYCLE:    csr_rdata = mcycle[31:0];
         CSR_MCYCLEH,   CSR_CYCLEH:   csr_rdata = mcycle[63:32];
         CSR_MINSTRET,  CSR_INSTRET:  csr_rdata = minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret[63:32];
`endif
         default: csr_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_mie   <= 1'b0;
         st_mpie  <= 1'b0;
         en_meie  <= 1'b0;
         en_mtie  <= 1'b0;
         mtvec_q  <= {MTVEC_RST[31:2], 2'b00};
         mepc_q   <= 32'd0;
         mcause_q <= 32'd0;
         wfi_pc   <= 32'd0;
      end else begin
         // Wake-up return address for a trap taken while sleeping
         if (wfi && !stall)
            wfi_pc <= ex_pc + 32'd4;

         if (interrupt_taken) begin
            mepc_q   <= {trap_epc[31:2], 2'b00};
            st_mpie  <= st_mie;
            st_mie   <= 1'b0;
            mcause_q <= (sensor_irq && en_meie) ? CAUSE_M_EXT : CAUSE_M_TIMER;
         end else if (mret_fire) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
         end else if (csr_we) begin
            case (csr_addr)
               CSR_MSTATUS: begin
                  st_mie  <= wval[BIT_MIE];
                  st_mpie <= wval[BIT_MPIE];
               end
               CSR_MIE: begin
                  en_meie <= wval[BIT_MEIE];
                  en_mtie <= wval[BIT_MTIE];
               end
               CSR_MTVEC:  mtvec_q  <= {wval[31:2], 2'b00};
               CSR_MEPC:   mepc_q   <= {wval[31:2], 2'b00};
               CSR_MCAUSE: mcause_q <= wval & MCAUSE_MASK;
               default: ;
            endcase
         end
      end
   end

   assign MEIE = st_mie && en_meie;
   assign MTIE = st_mie && en_mtie;

   // Redirect is a same-cycle pulse; reset suppresses it even mid-trap
   assign redirect    = !rst && (interrupt_taken || mret_fire);
   assign redirect_pc = interrupt_taken ? mtvec_q : mepc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_trap_unit
// Self-checking bench: directed scenarios followed by randomized traffic,
// all checked against a register-level reference model of the CSR file.
// -----------------------------------------------------------------------------
module tb_csr_trap_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        csr_en;
   logic [2:0]  csr_funct3;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic [31:0] ex_pc;
   logic        wfi;
   logic        mret;
   logic        instr_retire;
   logic        sensor_irq;
   logic        wdt_irq;
   logic        interrupt_taken;
   logic        wfi_mode;
   logic        MEIE;
   logic        MTIE;
   logic        redirect;
   logic [31:0] redirect_pc;

   always #5 clk = ~clk;

   csr_trap_unit #(.MTVEC_RST(32'h0001_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .csr_en          (csr_en),
      .csr_funct3      (csr_funct3),
      .csr_addr        (csr_addr),
      .csr_wdata       (csr_wdata),
      .csr_rdata       (csr_rdata),
      .ex_pc           (ex_pc),
      .wfi             (wfi),
      .mret            (mret),
      .instr_retire    (instr_retire),
      .sensor_irq      (sensor_irq),
      .wdt_irq         (wdt_irq),
      .interrupt_taken (interrupt_taken),
      .wfi_mode        (wfi_mode),
      .MEIE            (MEIE),
      .MTIE            (MTIE),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: whole-register values as software sees them
   logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_wfipc;
   logic [63:0] m_cyc, m_ret;
   bit          m_valid = 0;

   // Values sampled in the most recent tick, for directed checks
   logic [31:0] last_rdata, last_rpc;
   logic        last_redirect, last_meie, last_mtie;

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h344: return (32'(sensor_irq) << 11) | (32'(wdt_irq) << 7);
`ifdef CSR_COUNTERS_EN
         12'hB00, 12'hC00: return m_cyc[31:0];
         12'hB80, 12'hC80: return m_cyc[63:32];
         12'hB02, 12'hC02: return m_ret[31:0];
         12'hB82, 12'hC82: return m_ret[63:32];
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_mstatus = 32'h0000_1800;
      m_mie     = 32'd0;
      m_mtvec   = 32'h0001_0000;
      m_mepc    = 32'd0;
      m_mcause  = 32'd0;
      m_wfipc   = 32'd0;
      m_cyc     = 64'd0;
      m_ret     = 64'd0;
   endtask

   // One clock: check outputs at the falling edge, advance the model, then
   // return just after the rising edge so the caller can drive new inputs.
   task automatic tick();
      logic [31:0] old, nv;
      logic [1:0]  op;
      logic        it, mf, we, exp_redir;
      @(negedge clk);
      it        = interrupt_taken;
      mf        = mret && !stall && !it;
      exp_redir = !rst && (it || mf);
      if (m_valid) begin
         chk("rdata", csr_rdata, m_read(csr_addr));
         chk("redirect", {31'd0, redirect}, {31'd0, exp_redir});
         if (exp_redir)
            chk("redirect_pc", redirect_pc, it ? m_mtvec : m_mepc);
         chk("MEIE", {31'd0, MEIE}, {31'd0, m_mstatus[3] & m_mie[11]});
         chk("MTIE", {31'd0, MTIE}, {31'd0, m_mstatus[3] & m_mie[7]});
      end
      last_rdata    = csr_rdata;
      last_rpc      = redirect_pc;
      last_redirect = redirect;
      last_meie     = MEIE;
      last_mtie     = MTIE;

      if (rst) begin
         model_reset();
         m_valid = 1;
      end else begin
         op  = csr_funct3[1:0];
         old = m_read(csr_addr);
         we  = csr_en && !stall && !it && !mret && (op != 2'b00) &&
               (op == 2'b01 || csr_wdata != 32'd0);
         nv  = (op == 2'b01) ? csr_wdata :
               (op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
`ifdef CSR_COUNTERS_EN
         if (we && csr_addr == 12'hB00)      m_cyc[31:0]  = nv;
         else if (we && csr_addr == 12'hB80) m_cyc[63:32] = nv;
         else                                m_cyc        = m_cyc + 64'd1;
         if (we && csr_addr == 12'hB02)      m_ret[31:0]  = nv;
         else if (we && csr_addr == 12'hB82) m_ret[63:32] = nv;
         else if (instr_retire && !stall)    m_ret        = m_ret + 64'd1;
`endif
         if (it) begin
            m_mepc    = (wfi_mode ? m_wfipc : ex_pc) & ~32'd3;
            m_mcause  = (sensor_irq && m_mie[11]) ? 32'h8000_000B : 32'h8000_0007;
            m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
         end else if (mf) begin
            m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
         end else if (we) begin
            case (csr_addr)
               12'h300: m_mstatus = 32'h1800 | (nv & 32'h88);
               12'h304: m_mie     = nv & 32'h880;
               12'h305: m_mtvec   = nv & ~32'd3;
               12'h341: m_mepc    = nv & ~32'd3;
               12'h342: m_mcause  = nv & 32'h8000_000F;
               default: ;
            endcase
         end
         if (wfi && !stall) m_wfipc = ex_pc + 32'd4;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stall = 0; csr_en = 0; csr_funct3 = 3'b000; csr_wdata = 0;
      wfi = 0; mret = 0; instr_retire = 0; interrupt_taken = 0; wfi_mode = 0;
   endtask

   task automatic csr_op(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
      idle();
      csr_en = 1; csr_funct3 = {1'b0, op}; csr_addr = a; csr_wdata = d;
      tick();
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      idle();
      csr_addr = a;
      tick();
      chk(tag, last_rdata, exp);
   endtask

   logic [11:0] addr_tbl [18] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                                  12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                  12'hC02, 12'hC82, 12'h300, 12'h304, 12'h7C0, 12'h001};

   initial begin
      idle();
      rst = 1; csr_addr = 12'h300; ex_pc = 0; sensor_irq = 0; wdt_irq = 0;
      #1;
      // Reset, including a reset that collides with a trap entry
      interrupt_taken = 1; sensor_irq = 1;
      tick();
      tick();
      chk("rst_redirect", {31'd0, last_redirect}, 32'd0);
      chk("rst_mstatus", last_rdata, 32'h0000_1800);
      rst = 0; sensor_irq = 0;
      rd("rst_mtvec", 12'h305, 32'h0001_0000);
      rd("rst_mie", 12'h304, 32'h0);
      rd("rst_mepc", 12'h341, 32'h0);

      // Enable and interrupt entry
      csr_op(2'b01, 12'h304, 32'h800);
      csr_op(2'b10, 12'h300, 32'h8);
      idle(); sensor_irq = 1; interrupt_taken = 1; ex_pc = 32'h100;
      tick();
      chk("meie_pre", {31'd0, last_meie}, 32'd1);
      chk("trap_pc", last_rpc, 32'h0001_0000);
      sensor_irq = 0;
      rd("trap_mepc", 12'h341, 32'h100);
      rd("trap_mcause", 12'h342, 32'h8000_000B);
      rd("trap_mstatus", 12'h300, 32'h1880);
      chk("meie_post", {31'd0, last_meie}, 32'd0);

      // MRET
      idle(); mret = 1; ex_pc = 32'h180;
      tick();
      chk("mret_pc", last_rpc, 32'h100);
      rd("mret_mstatus", 12'h300, 32'h1888);
      chk("mret_meie", {31'd0, last_meie}, 32'd1);

      // WFI wakeup via timer
      idle(); wfi = 1; ex_pc = 32'h200;
      tick();
      csr_op(2'b10, 12'h304, 32'h80);
      idle(); wfi_mode = 1; wdt_irq = 1; interrupt_taken = 1; ex_pc = 32'h300;
      tick();
      wdt_irq = 0;
      rd("wfi_mepc", 12'h341, 32'h204);
      rd("wfi_mcause", 12'h342, 32'h8000_0007);

      // Set/clear semantics
      csr_op(2'b01, 12'h305, 32'h3003);
      rd("mtvec_rw", 12'h305, 32'h3000);
      csr_op(2'b11, 12'h304, 32'h80);
      rd("mie_rc", 12'h304, 32'h800);
      csr_op(2'b10, 12'h304, 32'h0);
      rd("mie_rs0", 12'h304, 32'h800);

      // Trap beats a simultaneous CSR write
      idle(); csr_en = 1; csr_funct3 = 3'b001; csr_addr = 12'h305; csr_wdata = 32'h5000;
      interrupt_taken = 1; ex_pc = 32'h400;
      tick();
      chk("sim_redirect", {31'd0, last_redirect}, 32'd1);
      rd("sim_mtvec", 12'h305, 32'h3000);

      // Stalled write waits for stall to drop
      idle(); stall = 1; csr_en = 1; csr_funct3 = 3'b001; csr_addr = 12'h305; csr_wdata = 32'h7000;
      tick();
      rd("stall_mtvec", 12'h305, 32'h3000);
      csr_op(2'b01, 12'h305, 32'h7000);
      rd("unstall_mtvec", 12'h305, 32'h7000);

`ifdef CSR_COUNTERS_EN
      // Counter carry across halves
      csr_op(2'b01, 12'hB00, 32'hFFFF_FFFF);
      csr_op(2'b01, 12'hB80, 32'h0);
      idle(); tick();
      rd("mcycleh", 12'hB80, 32'h1);
      // minstret counts only unstalled retirements
      csr_op(2'b01, 12'hB02, 32'h0);
      csr_op(2'b01, 12'hB82, 32'h0);
      for (int i = 0; i < 5; i++) begin
         idle(); instr_retire = 1; stall = (i == 1 || i == 3);
         tick();
      end
      rd("minstret", 12'hB02, 32'h3);
`else
      rd("cnt_absent", 12'hB00, 32'h0);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst             = ($urandom_range(0, 99) == 0);
         stall           = ($urandom_range(0, 3) == 0);
         csr_en          = 1'($urandom_range(0, 1));
         csr_funct3      = 3'($urandom);
         csr_addr        = addr_tbl[$urandom_range(0, 17)];
         csr_wdata       = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         ex_pc           = $urandom & ~32'd3;
         wfi             = ($urandom_range(0, 7) == 0);
         mret            = ($urandom_range(0, 7) == 0);
         instr_retire    = 1'($urandom_range(0, 1));
         sensor_irq      = 1'($urandom_range(0, 1));
         wdt_irq         = 1'($urandom_range(0, 1));
         interrupt_taken = ($urandom_range(0, 9) == 0);
         wfi_mode        = 1'($urandom_range(0, 1));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
